// File: rtl/key_cmd_decoder_pkg.sv
// Shared types, keycode constants and key classification for the keyboard command decoder.
// Optional macro KEY_ARROW_EN: USB arrow keys also classify as direction keys.
package pokemaze_key_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_ESC   = 8'h29;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_class_t;

    function automatic key_class_t classify(input logic [7:0] code);
        key_class_t kc;
        kc.valid = 1'b1;
        kc.dir   = UP;
        case (code)
            KC_W:     kc.dir = UP;
            KC_S:     kc.dir = DOWN;
            KC_A:     kc.dir = LEFT;
            KC_D:     kc.dir = RIGHT;
`ifdef KEY_ARROW_EN
            KC_UP:    kc.dir = UP;
            KC_DOWN:  kc.dir = DOWN;
            KC_LEFT:  kc.dir = LEFT;
            KC_RIGHT: kc.dir = RIGHT;
`endif
            default:  kc.valid = 1'b0;
        endcase
        return kc;
    endfunction

endpackage

// File: rtl/key_cmd_decoder_if.sv
// Keyboard/frame inputs and command outputs of the decoder, bundled as one interface.
interface key_cmd_decoder_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       enable;
    logic       frame_tick;
    logic       move_pulse;
    logic [1:0] move_dir;
    logic       start_pulse;
    logic       esc_pulse;
    logic [7:0] deb_code;

    modport master (
        output frame_clk, keycode, enable,
        input  frame_tick, move_pulse, move_dir, start_pulse, esc_pulse, deb_code
    );

    modport slave (
        input  frame_clk, keycode, enable,
        output frame_tick, move_pulse, move_dir, start_pulse, esc_pulse, deb_code
    );
endinterface

// File: rtl/key_cmd_decoder_debounce.sv
// Keycode debouncer: accepts a new code once it has been sampled unchanged for STABLE_CYCLES cycles.
module key_debounce #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [7:0] deb_code
);
    localparam int unsigned CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES - 1);
    // stab_cnt counts repeats after the first sample, so N samples are seen at count N-2
    localparam logic [CW-1:0] THR = CW'(STABLE_CYCLES - 2);

    logic [7:0]    prev;
    logic [CW-1:0] stab_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev     <= '0;
            stab_cnt <= '0;
            deb_code <= '0;
        end else begin
            prev <= keycode;
            if (keycode != prev)
                stab_cnt <= '0;
            else if (stab_cnt != SAT)
                stab_cnt <= stab_cnt + 1'b1;
            if (keycode == prev && keycode != deb_code && stab_cnt >= THR)
                deb_code <= keycode;
        end
    end
endmodule

// File: rtl/key_cmd_decoder.sv
// Keyboard command decoder: debounce, frame-strobe sync, auto-repeat move commands, Enter/Esc pulses.
// Optional macro KEY_ARROW_EN (see pokemaze_key_pkg) adds arrow keys as directions.
module key_cmd_decoder
    import pokemaze_key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_RATE   = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    key_cmd_decoder_if.slave   bus
);
    logic [7:0] deb_code;
    logic [7:0] deb_prev;
    logic [3:0] fsync;
    logic       frame_tick;
    logic       start_q, esc_q;

    key_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycode  (bus.keycode),
        .deb_code (deb_code)
    );

    // fsync[1:0] synchronise; fsync[3:2] place the edge detect so the tick lands 3 edges after capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync      <= '0;
            frame_tick <= 1'b0;
            deb_prev   <= '0;
            start_q    <= 1'b0;
            esc_q      <= 1'b0;
        end else begin
            fsync      <= {fsync[2:0], bus.frame_clk};
            frame_tick <= fsync[2] & ~fsync[3];
            deb_prev   <= deb_code;
            start_q    <= (deb_code == KC_ENTER) && (deb_prev != KC_ENTER);
            esc_q      <= (deb_code == KC_ESC) && (deb_prev != KC_ESC);
        end
    end

    rpt_state_t state, state_nxt;
    dir_t       cur_dir, cur_dir_nxt;
    dir_t       move_dir_q, move_dir_nxt;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic       move_q, move_nxt;
    key_class_t kc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            cur_dir    <= UP;
            move_dir_q <= UP;
            frame_cnt  <= '0;
            move_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_dir    <= cur_dir_nxt;
            move_dir_q <= move_dir_nxt;
            frame_cnt  <= frame_cnt_nxt;
            move_q     <= move_nxt;
        end
    end

    always_comb begin
        kc            = classify(deb_code);
        state_nxt     = state;
        cur_dir_nxt   = cur_dir;
        move_dir_nxt  = move_dir_q;
        frame_cnt_nxt = frame_cnt;
        move_nxt      = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.enable && kc.valid) begin
                state_nxt     = ST_PEND;
                cur_dir_nxt   = kc.dir;
                frame_cnt_nxt = '0;
            end
        // abort/redirect checks take priority over a coincident frame_tick
        end else if (!bus.enable || !kc.valid) begin
            state_nxt     = ST_IDLE;
            frame_cnt_nxt = '0;
        end else if (kc.dir != cur_dir) begin
            state_nxt     = ST_PEND;
            cur_dir_nxt   = kc.dir;
            frame_cnt_nxt = '0;
        end else if (frame_tick) begin
            case (state)
                ST_PEND: begin
                    move_nxt      = 1'b1;
                    move_dir_nxt  = cur_dir;
                    state_nxt     = ST_DELAY;
                    frame_cnt_nxt = '0;
                end
                ST_DELAY: begin
                    if (frame_cnt == 8'(REPEAT_DELAY - 1)) begin
                        move_nxt      = 1'b1;
                        move_dir_nxt  = cur_dir;
                        state_nxt     = ST_REPEAT;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                ST_REPEAT: begin
                    if (frame_cnt == 8'(REPEAT_RATE - 1)) begin
                        move_nxt      = 1'b1;
                        move_dir_nxt  = cur_dir;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.frame_tick  = frame_tick;
    assign bus.move_pulse  = move_q;
    assign bus.move_dir    = move_dir_q;
    assign bus.start_pulse = start_q;
    assign bus.esc_pulse   = esc_q;
    assign bus.deb_code    = deb_code;
endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed self-checking bench for key_cmd_decoder (STABLE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2).
module tb_key_cmd_decoder;
    logic Clk = 1'b0;
    logic Reset;
    key_cmd_decoder_if bus();

    key_cmd_decoder #(
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (3),
        .REPEAT_RATE  (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] kc;
        logic       en;
        int         pulses;
        int         dir;
    } vec_t;

    vec_t vt[$];
    int total = 0;
    int bad   = 0;
    int mp_cnt, esc_cnt, st_cnt, tick_cnt, last_dir;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        mp_cnt = 0; esc_cnt = 0; st_cnt = 0; tick_cnt = 0; last_dir = -1;
    endtask

    // one cycle: inputs are driven right after the sampling negedge
    task automatic cyc();
        @(negedge Clk);
        if (bus.move_pulse) begin
            mp_cnt++;
            last_dir = int'(bus.move_dir);
        end
        if (bus.esc_pulse)   esc_cnt++;
        if (bus.start_pulse) st_cnt++;
        if (bus.frame_tick)  tick_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic add(input logic [7:0] kc, input logic en, input int p, input int d);
        vec_t v;
        v.kc = kc; v.en = en; v.pulses = p; v.dir = d;
        vt.push_back(v);
    endtask

    initial begin
        int arrow_p, arrow_d;
        int deb_nz;
        int tick_exp[5];
`ifdef KEY_ARROW_EN
        arrow_p = 1; arrow_d = 3;
`else
        arrow_p = 0; arrow_d = 0;
`endif
        tick_exp = '{0, 0, 0, 1, 0};

        add(8'h1A, 1, 1, 0); add(8'h1A, 1, 0, 0); add(8'h1A, 1, 0, 0);
        add(8'h1A, 1, 1, 0); add(8'h1A, 1, 0, 0); add(8'h1A, 1, 1, 0);
        add(8'h1A, 1, 0, 0); add(8'h1A, 1, 1, 0); add(8'h1A, 1, 0, 0);
        add(8'h1A, 1, 1, 0);
        add(8'h00, 1, 0, 0);
        add(8'h04, 1, 1, 2); add(8'h04, 1, 0, 0);
        add(8'h07, 1, 1, 3); add(8'h07, 1, 0, 0); add(8'h07, 1, 0, 0);
        add(8'h07, 1, 1, 3);
        add(8'h00, 1, 0, 0);
        add(8'h16, 1, 1, 1); add(8'h16, 1, 0, 0); add(8'h16, 1, 0, 0);
        add(8'h16, 1, 1, 1); add(8'h16, 1, 0, 0);
        add(8'h16, 0, 0, 0); add(8'h16, 0, 0, 0);
        add(8'h16, 1, 1, 1); add(8'h16, 1, 0, 0);
        add(8'h29, 1, 0, 0);
        add(8'h4F, 1, arrow_p, arrow_d);
        add(8'h00, 1, 0, 0);

        // reset held with W on the bus
        Reset = 1'b1; bus.keycode = 8'h1A; bus.enable = 1'b0; bus.frame_clk = 1'b0;
        clr();
        run(3);
        chk("reset_deb", int'(bus.deb_code), 0);
        chk("reset_outs", int'({bus.frame_tick, bus.move_pulse, bus.move_dir,
                                bus.start_pulse, bus.esc_pulse}), 0);
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("deb_after_reset_%0d", k), int'(bus.deb_code), (k == 4) ? 8'h1A : 8'h00);
        end

        // frame strobe latency, enable low so no moves
        clr();
        bus.frame_clk = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("tick_e%0d", k), int'(bus.frame_tick), tick_exp[k]);
        end
        run(3);
        bus.frame_clk = 1'b0;
        run(6);
        chk("tick_once", tick_cnt, 1);
        chk("no_move_en0", mp_cnt, 0);

        // glitch shorter than the debounce window
        bus.keycode = 8'h00;
        run(6);
        chk("deb_cleared", int'(bus.deb_code), 0);
        bus.enable = 1'b1;
        clr();
        deb_nz = 0;
        bus.keycode = 8'h07;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (bus.deb_code != 8'h00) deb_nz++;
        end
        bus.keycode = 8'h00;
        bus.frame_clk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus.deb_code != 8'h00) deb_nz++;
        end
        bus.frame_clk = 1'b0;
        run(4);
        chk("glitch_deb", deb_nz, 0);
        chk("glitch_move", mp_cnt, 0);

        // one frame per table row: settle, then a full frame_clk period
        foreach (vt[i]) begin
            clr();
            bus.keycode = vt[i].kc;
            bus.enable  = vt[i].en;
            run(8);
            bus.frame_clk = 1'b1;
            run(8);
            bus.frame_clk = 1'b0;
            run(4);
            chk($sformatf("row%0d_pulses", i), mp_cnt, vt[i].pulses);
            chk($sformatf("row%0d_deb", i), int'(bus.deb_code), int'(vt[i].kc));
            if (vt[i].pulses > 0)
                chk($sformatf("row%0d_dir", i), last_dir, vt[i].dir);
        end

        // held Esc and Enter each give exactly one pulse
        clr();
        bus.keycode = 8'h29;
        run(100);
        chk("esc_once", esc_cnt, 1);
        chk("esc_no_start", st_cnt, 0);
        bus.keycode = 8'h00;
        run(10);
        clr();
        bus.keycode = 8'h28;
        run(60);
        chk("start_once", st_cnt, 1);
        chk("start_no_esc", esc_cnt, 0);
        chk("action_no_move", mp_cnt, 0);

        // reset lands on the edge that would register a move pulse
        bus.keycode = 8'h1A;
        run(10);
        clr();
        bus.frame_clk = 1'b1;
        run(4);
        chk("pre_reset_tick", int'(bus.frame_tick), 1);
        Reset = 1'b1;
        cyc();
        chk("midreset_move", int'(bus.move_pulse), 0);
        chk("midreset_deb", int'(bus.deb_code), 0);
        chk("midreset_tick", int'(bus.frame_tick), 0);
        Reset = 1'b0;
        bus.frame_clk = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
